// File: rtl/deserializer.sv
// SPI receive side: oversamples n_cs/spi_clk/mosi in the clk domain,
// assembles {opcode, addr, data} MSB first and hands it off via valid/ready.
module deserializer #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int DATAW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               n_cs,
  input  logic               spi_clk,
  input  logic               mosi,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [OPCODEW-1:0] opcode_out,
  output logic [ADDRW-1:0]   addr_out,
  output logic [DATAW-1:0]   data_out,
  output logic               busy,
  output logic               err
);

  localparam int FRAME_W = OPCODEW + ADDRW + DATAW;
  localparam int CW      = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic cs_s1, cs_s2, cs_q;
  logic sck_s1, sck_s2, sck_q;
  logic mosi_s1, mosi_s2;

  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_next;
  logic [CW-1:0]      cnt;

  logic rise, cs_fall, cs_rise;
  logic complete, abort, overrun, load;

  // two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_q    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= n_cs;
      cs_s2   <= cs_s1;
      cs_q    <= cs_s2;
      sck_s1  <= spi_clk;
      sck_s2  <= sck_s1;
      sck_q   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise       = ~sck_q & sck_s2;
  assign cs_fall    = cs_q & ~cs_s2;
  assign cs_rise    = ~cs_q & cs_s2;
  assign frame_next = {shreg[FRAME_W-2:0], mosi_s2};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state; a final bit wins over a coincident cs_rise
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (rise && cnt == CW'(FRAME_W - 1)) begin
          state_d  = DONE;
          complete = 1'b1;
        end else if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // shift register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state_q == IDLE && cs_fall) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state_q == SHIFT && rise) begin
      shreg <= frame_next;
      cnt   <= cnt + CW'(1);
    end
  end

  assign load    = complete & (~valid_out | ready_in);
  assign overrun = complete & valid_out & ~ready_in;

  // single-entry output holding register and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      opcode_out <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      err        <= 1'b0;
    end else begin
      err <= abort | overrun;
      if (load) begin
        valid_out  <= 1'b1;
        opcode_out <= frame_next[FRAME_W-1 -: OPCODEW];
        addr_out   <= frame_next[DATAW +: ADDRW];
        data_out   <= frame_next[DATAW-1:0];
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: nominal, abort, overrun,
// back-to-back reload, extra clocks, noise and mid-frame reset.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst, n_cs, spi_clk, mosi, ready_in;
  logic       valid_out, busy, err;
  logic [1:0] opcode_out;
  logic [7:0] addr_out, data_out;

  int total = 0;
  int bad   = 0;

  int         err_cnt = 0, dbl_cnt = 0, hs_cnt = 0, busy_cnt = 0;
  logic       err_q = 1'b0;
  logic [1:0] last_op = '0;
  logic [7:0] last_addr = '0, last_data = '0;
  logic       busy_mid = 1'b0;

  int e0, h0, b0;

  deserializer dut (
    .clk(clk), .rst(rst), .n_cs(n_cs), .spi_clk(spi_clk),
    .mosi(mosi), .ready_in(ready_in), .valid_out(valid_out),
    .opcode_out(opcode_out), .addr_out(addr_out),
    .data_out(data_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // event monitor sampled on the inactive edge
  always @(negedge clk) begin
    err_q <= (err === 1'b1);
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (err === 1'b1 && err_q) dbl_cnt <= dbl_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (valid_out === 1'b1 && ready_in === 1'b1) begin
      hs_cnt    <= hs_cnt + 1;
      last_op   <= opcode_out;
      last_addr <= addr_out;
      last_data <= data_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // n rises on spi_clk, 8 clk per spi period; b2b pulses ready_in
  // for exactly the cycle in which the last rise is detected
  task automatic shift_bits(input logic [17:0] f, input int n,
                            input bit b2b);
    for (int i = 0; i < n; i++) begin
      mosi    = (i < 18) ? f[17-i] : 1'b1;
      spi_clk = 1'b0;
      tick(4);
      spi_clk = 1'b1;
      if (b2b && i == n - 1) begin
        tick(2);
        ready_in = 1'b1;
        tick(1);
        ready_in = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      if (i == 5) busy_mid = busy;
    end
    spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic frame(input logic [17:0] f, input int n,
                       input bit b2b);
    n_cs = 1'b0;
    tick(4);
    shift_bits(f, n, b2b);
    n_cs = 1'b1;
    tick(8);
  endtask

  initial begin
    rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0;
    mosi = 1'b0; ready_in = 1'b0;
    tick(3);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_op", opcode_out, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b0;
    tick(2);

    // nominal frame
    ready_in = 1'b1;
    e0 = err_cnt; h0 = hs_cnt;
    frame({2'b10, 8'hA5, 8'h3C}, 18, 1'b0);
    chk("nom_busy_mid", busy_mid, 1);
    chk("nom_busy_after", busy, 0);
    chk("nom_hs", hs_cnt - h0, 1);
    chk("nom_op", last_op, 2'b10);
    chk("nom_addr", last_addr, 8'hA5);
    chk("nom_data", last_data, 8'h3C);
    chk("nom_err", err_cnt - e0, 0);
    chk("nom_valid_end", valid_out, 0);

    // abort after 11 bits, then a full frame
    e0 = err_cnt; h0 = hs_cnt;
    frame({2'b11, 8'hAA, 8'h55}, 11, 1'b0);
    chk("abort_err", err_cnt - e0, 1);
    chk("abort_hs", hs_cnt - h0, 0);
    chk("abort_valid", valid_out, 0);
    chk("abort_dbl", dbl_cnt, 0);
    frame({2'b01, 8'h0F, 8'hF0}, 18, 1'b0);
    chk("post_abort_hs", hs_cnt - h0, 1);
    chk("post_abort_op", last_op, 2'b01);
    chk("post_abort_addr", last_addr, 8'h0F);
    chk("post_abort_data", last_data, 8'hF0);
    chk("post_abort_err", err_cnt - e0, 1);

    // backpressure and overrun
    ready_in = 1'b0;
    e0 = err_cnt; h0 = hs_cnt;
    frame({2'b11, 8'h01, 8'h02}, 18, 1'b0);
    chk("bp_valid", valid_out, 1);
    chk("bp_op", opcode_out, 2'b11);
    chk("bp_addr", addr_out, 8'h01);
    chk("bp_data", data_out, 8'h02);
    chk("bp_err", err_cnt - e0, 0);
    frame({2'b00, 8'hFF, 8'hEE}, 18, 1'b0);
    chk("ovr_err", err_cnt - e0, 1);
    chk("ovr_dbl", dbl_cnt, 0);
    chk("ovr_valid", valid_out, 1);
    chk("ovr_op", opcode_out, 2'b11);
    chk("ovr_addr", addr_out, 8'h01);
    chk("ovr_data", data_out, 8'h02);
    ready_in = 1'b1;
    tick(1);
    chk("ovr_drain_valid", valid_out, 0);
    chk("ovr_drain_hs", hs_cnt - h0, 1);
    chk("ovr_drain_addr", last_addr, 8'h01);
    chk("ovr_drain_data", last_data, 8'h02);

    // back-to-back: consume A in the cycle B completes
    ready_in = 1'b0;
    e0 = err_cnt; h0 = hs_cnt;
    frame({2'b01, 8'h33, 8'h44}, 18, 1'b0);
    chk("b2b_a_valid", valid_out, 1);
    chk("b2b_a_addr", addr_out, 8'h33);
    frame({2'b10, 8'h55, 8'h66}, 18, 1'b1);
    chk("b2b_valid", valid_out, 1);
    chk("b2b_hs", hs_cnt - h0, 1);
    chk("b2b_hs_addr", last_addr, 8'h33);
    chk("b2b_op", opcode_out, 2'b10);
    chk("b2b_addr", addr_out, 8'h55);
    chk("b2b_data", data_out, 8'h66);
    chk("b2b_err", err_cnt - e0, 0);
    ready_in = 1'b1;
    tick(1);
    chk("b2b_drain_valid", valid_out, 0);
    chk("b2b_drain_data", last_data, 8'h66);

    // 22 rises in one window keep only the first 18 bits
    e0 = err_cnt; h0 = hs_cnt;
    frame({2'b00, 8'hC3, 8'h5A}, 22, 1'b0);
    chk("extra_hs", hs_cnt - h0, 1);
    chk("extra_op", last_op, 2'b00);
    chk("extra_addr", last_addr, 8'hC3);
    chk("extra_data", last_data, 8'h5A);
    chk("extra_err", err_cnt - e0, 0);

    // spi_clk toggles with n_cs high
    e0 = err_cnt; h0 = hs_cnt; b0 = busy_cnt;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
      tick(4);
    end
    tick(4);
    chk("noise_busy", busy_cnt - b0, 0);
    chk("noise_hs", hs_cnt - h0, 0);
    chk("noise_err", err_cnt - e0, 0);
    chk("noise_valid", valid_out, 0);

    // reset mid-frame with a frame held at the output
    ready_in = 1'b0;
    e0 = err_cnt;
    frame({2'b11, 8'h77, 8'h88}, 18, 1'b0);
    chk("rstm_held", valid_out, 1);
    n_cs = 1'b0;
    tick(4);
    shift_bits({2'b01, 8'h12, 8'h34}, 9, 1'b0);
    chk("rstm_busy_pre", busy, 1);
    rst = 1'b1; n_cs = 1'b1; spi_clk = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rstm_valid", valid_out, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_err", err, 0);
    chk("rstm_op", opcode_out, 0);
    chk("rstm_addr", addr_out, 0);
    chk("rstm_data", data_out, 0);
    tick(4);
    ready_in = 1'b1;
    h0 = hs_cnt;
    frame({2'b10, 8'h9C, 8'h2D}, 18, 1'b0);
    chk("rstm_hs", hs_cnt - h0, 1);
    chk("rstm_f_op", last_op, 2'b10);
    chk("rstm_f_addr", last_addr, 8'h9C);
    chk("rstm_f_data", last_data, 8'h2D);
    chk("rstm_no_err", err_cnt - e0, 0);
    chk("final_dbl", dbl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
